// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q      = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, subtract-restore for divide.
// acc holds {hi, lo}: multiply keeps the running product in hi and the multiplier
// in lo; divide shifts the dividend out of lo[31] and quotient bits into lo[0].
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] rem_in,
    input  logic [31:0] b,
    output logic [63:0] acc_out,
    output logic [31:0] rem_out
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [33:0] diff;

    // Select between one multiply step and one restoring-divide step
    always_comb begin
        sum    = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, b} : 33'd0);
        rem_sh = {rem_in, acc_in[31]};
        diff   = {1'b0, rem_sh} - {2'b00, b};
        if (is_div) begin
            // A negative difference means the divisor did not fit: keep the shifted remainder
            rem_out = diff[33] ? rem_sh[31:0] : diff[31:0];
            acc_out = {acc_in[63:32], acc_in[30:0], ~diff[33]};
        end else begin
            rem_out = rem_in;
            acc_out = {sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_e           state;
    logic [2:0]       op_r;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;
    logic [31:0]      rem;
    logic [31:0]      mag_b;
    logic             neg_res;
    logic             neg_rem;

    logic             a_sgn, b_sgn, div_zero, ovf;
    logic [31:0]      mag_a_in, mag_b_in, special_res;
    logic [63:0]      step_acc, prod;
    logic [31:0]      step_rem, fix_val;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    muldiv_step u_step (
        .is_div  (op_r[2]),
        .acc_in  (acc),
        .rem_in  (rem),
        .b       (mag_b),
        .acc_out (step_acc),
        .rem_out (step_rem)
    );

    // Request decode: operand signedness, magnitudes and the short-circuit cases
    always_comb begin
        // MUL low bits do not depend on signedness, so it shares the signed path
        a_sgn = rs1[31] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                            op == OP_DIV || op == OP_REM);
        b_sgn = rs2[31] && (op == OP_MUL || op == OP_MULH ||
                            op == OP_DIV || op == OP_REM);
        mag_a_in = a_sgn ? (~rs1 + 32'd1) : rs1;
        mag_b_in = b_sgn ? (~rs2 + 32'd1) : rs2;
        div_zero = op[2] && (rs2 == 32'd0);
        ovf      = (op == OP_DIV || op == OP_REM) && (rs1 == OVF_Q) && (rs2 == 32'hFFFF_FFFF);
        if (div_zero) special_res = op[1] ? rs1 : DIV_ZERO_Q;
        else          special_res = op[1] ? 32'd0 : OVF_Q;
    end

    // Sign correction applied once the magnitude result is complete
    always_comb begin
        prod = neg_res ? (~acc + 64'd1) : acc;
        if (op_r[2]) begin
            if (op_r[1]) fix_val = neg_rem ? (~rem + 32'd1) : rem;
            else         fix_val = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        end else begin
            fix_val = (op_r == OP_MUL) ? prod[31:0] : prod[63:32];
        end
    end

    // Control FSM and datapath registers; flush drops any in-flight or pending result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= 3'd0;
            cnt       <= '0;
            acc       <= 64'd0;
            rem       <= 32'd0;
            mag_b     <= 32'd0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r <= op;
                        if (div_zero || ovf) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            acc     <= {32'd0, mag_a_in};
                            rem     <= 32'd0;
                            mag_b   <= mag_b_in;
                            neg_res <= a_sgn ^ b_sgn;
                            neg_rem <= a_sgn;
                            cnt     <= '0;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    rem <= step_rem;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= S_FIX;
                end
                S_FIX: begin
                    result    <= fix_val;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corners, backpressure, abort, random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic straight from the RV32M rules
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p  = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov)     return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ov)     return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ov;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && ov))) return 1;
        return 34;
    endfunction

    // Called just after the acceptance edge: counts cycles to out_valid, checks the value
    task automatic wait_result(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_latency(o, a, b)));
        chk({tag, "_res"}, {32'd0, result}, {32'd0, ref_res(o, a, b)});
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // Full transaction with `hold` cycles of out_ready=0 in DONE
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] held;
        wait_idle();
        in_valid  = 1'b1;
        op        = o;
        rs1       = a;
        rs2       = b;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        wait_result(tag, o, a, b);
        held = result;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_res"}, {32'd0, result}, {32'd0, held});
            chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_post_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ov_cnt;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed corners
        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("divu",   3'd5, 32'd100,        32'd7,         0);
        run_op("remu",   3'd7, 32'd100,        32'd7,         0);
        run_op("div0",   3'd4, 32'd5,          32'd0,         0);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         0);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("remu0",  3'd7, 32'h1234_5678,  32'd0,         1);
        run_op("divu0",  3'd5, 32'h1234_5678,  32'd0,         0);

        // Backpressure, then a request offered on the handshake edge
        wait_idle();
        in_valid = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd33; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_result("bp", 3'd5, 32'd1000, 32'd33);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_res", {32'd0, result}, {32'd0, ref_res(3'd5, 32'd1000, 32'd33)});
            chk("bp_rdy", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd7; rs1 = 32'd1000; rs2 = 32'd33;
        tick();
        chk("bp_hs_vld", 64'(out_valid), 64'd0);
        chk("bp_hs_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_busy", 64'(busy), 64'd1);
        wait_result("bp_next", 3'd7, 32'd1000, 32'd33);
        tick();

        // Request coinciding with flush is dropped
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_req_rdy", 64'(in_ready), 64'd1);
        chk("flush_req_busy", 64'(busy), 64'd0);

        // Flush during CALC at counter 10
        in_valid = 1'b1; op = 3'd4; rs1 = 32'd12345; rs2 = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rdy", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_vld", 64'(out_valid), 64'd0);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        chk("flush_never_valid", 64'(ov_cnt), 64'd0);

        // Reset during CALC behaves like flush and clears outputs
        in_valid = 1'b1; op = 3'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_rdy", 64'(in_ready), 64'd1);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_vld", 64'(out_valid), 64'd0);
        chk("mrst_res", {32'd0, result}, 64'd0);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        chk("mrst_never_valid", 64'(ov_cnt), 64'd0);

        // Random operations against the reference
        for (int k = 0; k < 30; k++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op("rand", ro, ra, rb, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
